// File: rtl/asteroid_pkg.sv
// asteroid_pkg: shared encodings and helpers for the asteroid wave scheduler.
// Revision 1.0
`default_nettype none

package asteroid_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_PLAY    = 2'b01,
      ST_RESPAWN = 2'b10,
      ST_OVER    = 2'b11
   } game_state_t;

   localparam int         N_SLOTS   = 8;
   localparam logic [2:0] LEVEL_MAX = 3'd7;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/asteroid_wave_scheduler_if.sv
// asteroid_wave_scheduler_if: game-tick inputs and asteroid/game status outputs.
// Revision 1.0
`default_nettype none

interface asteroid_wave_scheduler_if;
   logic       tick;
   logic       start;
   logic [7:0] a_hit;
   logic       ship_hit;
   logic [7:0] a_state;
   logic       invuln;
   logic [1:0] game_state;
   logic [1:0] lives;
   logic [2:0] level;

   modport master (
      output tick, start, a_hit, ship_hit,
      input  a_state, invuln, game_state, lives, level
   );

   modport slave (
      input  tick, start, a_hit, ship_hit,
      output a_state, invuln, game_state, lives, level
   );
endinterface

`default_nettype wire

// File: rtl/rr_pick.sv
// rr_pick: combinational 8-way round-robin picker starting at i_ptr.
// Revision 1.0
`default_nettype none

module rr_pick
   import asteroid_pkg::*;
(
   input  logic [N_SLOTS-1:0] i_avail,
   input  logic [2:0]         i_ptr,
   output logic [N_SLOTS-1:0] o_grant_onehot,
   output logic [2:0]         o_grant_idx,
   output logic               o_valid
);

   logic [2:0] w_idx;

   always_comb begin
      o_grant_onehot = '0;
      o_grant_idx    = '0;
      o_valid        = 1'b0;
      w_idx          = '0;
      for (int off = 0; off < N_SLOTS; off++) begin
         w_idx = i_ptr + 3'(off);
         if (!o_valid && i_avail[w_idx]) begin
            o_valid               = 1'b1;
            o_grant_idx           = w_idx;
            o_grant_onehot[w_idx] = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/asteroid_wave_scheduler.sv
// asteroid_wave_scheduler: game FSM, lives/level tracking and round-robin asteroid respawn.
// Revision 1.0
`default_nettype none

module asteroid_wave_scheduler
   import asteroid_pkg::*;
#(
   parameter int LIVES         = 3,
   parameter int SPAWN_TICKS   = 45,
   parameter int RESPAWN_TICKS = 60,
   parameter int LEVEL_TICKS   = 300
)(
   input  logic                       clock,
   input  logic                       resetn,
   asteroid_wave_scheduler_if.slave   bus
);

   localparam int c_SPW = (SPAWN_TICKS   > 1) ? $clog2(SPAWN_TICKS)   : 1;
   localparam int c_RPW = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
   localparam int c_LCW = (LEVEL_TICKS   > 1) ? $clog2(LEVEL_TICKS)   : 1;
   localparam logic [c_SPW-1:0] c_SPAWN_RELOAD   = c_SPW'(SPAWN_TICKS - 1);
   localparam logic [c_RPW-1:0] c_RESPAWN_RELOAD = c_RPW'(RESPAWN_TICKS - 1);
   localparam logic [c_LCW-1:0] c_LEVEL_LAST     = c_LCW'(LEVEL_TICKS - 1);
   localparam logic [1:0]       c_LIVES_INIT     = 2'(LIVES);

   game_state_t      r_state, w_nxt_state;
   logic [7:0]       r_a_state, w_nxt_a_state;
   logic             r_invuln, w_nxt_invuln;
   logic [1:0]       r_lives, w_nxt_lives;
   logic [2:0]       r_level, w_nxt_level;
   logic [c_SPW-1:0] r_spawn_timer, w_nxt_spawn_timer;
   logic [2:0]       r_rr_ptr, w_nxt_rr_ptr;
   logic [c_LCW-1:0] r_level_cnt, w_nxt_level_cnt;
   logic [c_RPW-1:0] r_respawn_cnt, w_nxt_respawn_cnt;
   logic             r_ship_hit_q;

   logic             w_start_game, w_live, w_ship_edge;
   logic [2:0]       w_cur_level;
   logic [c_SPW-1:0] w_cur_timer;
   logic [7:0]       w_after_hit, w_avail, w_grant_onehot;
   logic [3:0]       w_active_cnt, w_target;
   logic [2:0]       w_grant_idx;
   logic             w_grant_valid;

   // A start tick behaves like a live tick on a freshly initialised game.
   assign w_start_game = ((r_state == ST_IDLE) || (r_state == ST_OVER)) && bus.start;
   assign w_live       = (r_state == ST_PLAY) || (r_state == ST_RESPAWN);
   assign w_ship_edge  = bus.ship_hit && !r_ship_hit_q;
   assign w_cur_level  = w_start_game ? 3'd1 : r_level;
   assign w_cur_timer  = w_start_game ? '0 : r_spawn_timer;
   assign w_after_hit  = r_a_state & ~bus.a_hit;
   assign w_avail      = ~(r_a_state | bus.a_hit);
   assign w_active_cnt = popcount8(w_after_hit);
   assign w_target     = {1'b0, w_cur_level} + 4'd1;

   rr_pick u_rr_pick (
      .i_avail        (w_avail),
      .i_ptr          (r_rr_ptr),
      .o_grant_onehot (w_grant_onehot),
      .o_grant_idx    (w_grant_idx),
      .o_valid        (w_grant_valid)
   );

   always_comb begin
      w_nxt_state       = r_state;
      w_nxt_a_state     = r_a_state;
      w_nxt_invuln      = r_invuln;
      w_nxt_lives       = r_lives;
      w_nxt_level       = r_level;
      w_nxt_level_cnt   = r_level_cnt;
      w_nxt_spawn_timer = r_spawn_timer;
      w_nxt_rr_ptr      = r_rr_ptr;
      w_nxt_respawn_cnt = r_respawn_cnt;

      if (w_start_game) begin
         w_nxt_state     = ST_PLAY;
         w_nxt_lives     = c_LIVES_INIT;
         w_nxt_level     = 3'd1;
         w_nxt_level_cnt = '0;
         w_nxt_invuln    = 1'b0;
      end else if (w_live) begin
         if (r_level_cnt == c_LEVEL_LAST) begin
            w_nxt_level_cnt = '0;
            if (r_level != LEVEL_MAX) begin
               w_nxt_level = r_level + 3'd1;
            end
         end else begin
            w_nxt_level_cnt = r_level_cnt + c_LCW'(1);
         end
      end

      if (w_start_game || w_live) begin
         w_nxt_a_state = w_after_hit;
         if (w_active_cnt < w_target) begin
            if (w_cur_timer == '0) begin
               w_nxt_spawn_timer = '0;
               if (w_grant_valid) begin
                  w_nxt_a_state     = w_after_hit | w_grant_onehot;
                  w_nxt_spawn_timer = c_SPAWN_RELOAD;
                  w_nxt_rr_ptr      = w_grant_idx + 3'd1;
               end
            end else begin
               w_nxt_spawn_timer = w_cur_timer - c_SPW'(1);
            end
         end else begin
            w_nxt_spawn_timer = w_cur_timer;
         end
      end

      // Ship handling runs last so a final-life hit can clear the field.
      case (r_state)
         ST_PLAY: begin
            if (w_ship_edge) begin
               w_nxt_lives = r_lives - 2'd1;
               if (r_lives == 2'd1) begin
                  w_nxt_state   = ST_OVER;
                  w_nxt_a_state = '0;
               end else begin
                  w_nxt_state       = ST_RESPAWN;
                  w_nxt_respawn_cnt = c_RESPAWN_RELOAD;
                  w_nxt_invuln      = 1'b1;
               end
            end
         end
         ST_RESPAWN: begin
            if (r_respawn_cnt == '0) begin
               w_nxt_state  = ST_PLAY;
               w_nxt_invuln = 1'b0;
            end else begin
               w_nxt_respawn_cnt = r_respawn_cnt - c_RPW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state       <= ST_IDLE;
         r_a_state     <= '0;
         r_invuln      <= 1'b0;
         r_lives       <= c_LIVES_INIT;
         r_level       <= 3'd1;
         r_spawn_timer <= '0;
         r_rr_ptr      <= '0;
         r_level_cnt   <= '0;
         r_respawn_cnt <= '0;
         r_ship_hit_q  <= 1'b0;
      end else if (bus.tick) begin
         r_state       <= w_nxt_state;
         r_a_state     <= w_nxt_a_state;
         r_invuln      <= w_nxt_invuln;
         r_lives       <= w_nxt_lives;
         r_level       <= w_nxt_level;
         r_spawn_timer <= w_nxt_spawn_timer;
         r_rr_ptr      <= w_nxt_rr_ptr;
         r_level_cnt   <= w_nxt_level_cnt;
         r_respawn_cnt <= w_nxt_respawn_cnt;
         r_ship_hit_q  <= bus.ship_hit;
      end
   end

   assign bus.a_state    = r_a_state;
   assign bus.invuln     = r_invuln;
   assign bus.game_state = r_state;
   assign bus.lives      = r_lives;
   assign bus.level      = r_level;

endmodule

`default_nettype wire
